// File: rtl/aoi221_bist_ctrl.sv
// -----------------------------------------------------------------------------
// aoi221_bist_ctrl
//
// Self-test controller wrapped around one AOI221 cell. It walks the cell's
// five inputs through all 32 patterns. Each pattern is held for
// SETTLE_CYCLES+1 cycles. On the last hold cycle it compares the cell's ZN
// output with the golden function ZN = ~(A | (B1&B2) | (C1&C2)).
//
// At the end of a run it reports pass/fail, a saturating mismatch count and
// the index of the first failing vector.
//
// Parameters:
//   SETTLE_CYCLES  extra hold cycles per vector before ZN is sampled (0..15)
//   ERR_CNT_W      width of the saturating mismatch counter (>= 1)
//
// Optional feature (compile-time macro AOI221_BIST_FAILMAP_EN):
//   When defined, adds a 32-bit FAIL_MAP output. Bit k is set when vector k
//   mismatched in the current or last run. When undefined, neither the port
//   nor its flops exist.
//
// Ports:
//   CK         in   clock, rising edge
//   RN         in   asynchronous active-low reset; aborts any run in progress
//   START      in   begin a 32-vector run (honoured in IDLE and FIN only)
//   ZN_IN      in   ZN from the cell under test
//   A..C2      out  registered stimulus, {A,B1,B2,C1,C2} = VEC[4:0]
//   BUSY       out  high while vectors are being applied (RUN state)
//   DONE       out  one-cycle pulse in the first FIN cycle
//   PASS       out  last completed run had zero mismatches; held until START
//   ERR_CNT    out  mismatch count of the current/last run, saturating
//   FAIL_VLD   out  at least one mismatch in the current/last run
//   FAIL_VEC   out  first mismatching vector index (valid when FAIL_VLD=1)
//   FAIL_MAP   out  per-vector mismatch bitmap (only with the macro above)
//   DBG_STATE  out  current FSM state encoding, for checkers and debug
//
// Handshake: START is a level-sampled request. It is accepted on any rising
// edge where the FSM is in IDLE or FIN. It is ignored while BUSY is high.
// -----------------------------------------------------------------------------
module aoi221_bist_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_CNT_W     = 6
) (
    input  logic                 CK,
    input  logic                 RN,
    input  logic                 START,
    input  logic                 ZN_IN,
    output logic                 A,
    output logic                 B1,
    output logic                 B2,
    output logic                 C1,
    output logic                 C2,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 PASS,
    output logic [ERR_CNT_W-1:0] ERR_CNT,
    output logic                 FAIL_VLD,
    output logic [4:0]           FAIL_VEC,
`ifdef AOI221_BIST_FAILMAP_EN
    output logic [31:0]          FAIL_MAP,
`endif
    output logic [1:0]           DBG_STATE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam logic [3:0]           LP_SETTLE  = 4'(SETTLE_CYCLES);
    localparam logic [ERR_CNT_W-1:0] LP_ERR_MAX = '1;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [4:0]             r_vec;
    logic [3:0]             r_hold;
    logic [4:0]             r_stim;
    logic [ERR_CNT_W-1:0]   r_err_cnt;
    logic                   r_fail_vld;
    logic [4:0]             r_fail_vec;
    logic                   r_pass;

    logic                   w_busy;
    logic                   w_done;
    logic                   w_start_take;
    logic                   w_last_hold;
    logic                   w_last_vec;
    logic                   w_golden;
    logic                   w_mismatch;

    // START is only accepted outside RUN.
    assign w_start_take = START && (r_state != ST_RUN);

    // This is the compare cycle: the current vector has been held long enough.
    assign w_last_hold  = (r_state == ST_RUN) && (r_hold == LP_SETTLE);
    assign w_last_vec   = (r_vec == 5'd31);

    assign w_golden     = ~(r_vec[4] | (r_vec[3] & r_vec[2]) | (r_vec[1] & r_vec[0]));

    // Case inequality makes an X or Z on ZN_IN count as a mismatch in
    // simulation. Synthesis treats it as an ordinary inequality.
    assign w_mismatch   = (ZN_IN !== w_golden);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (w_last_hold && w_last_vec) begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                // FIN lasts exactly one cycle, so DONE is a single pulse.
                // A START held through FIN restarts on the next edge.
                w_done      = 1'b1;
                w_state_nxt = START ? ST_RUN : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Vector sequencing, stimulus and result capture
    // ------------------------------------------------------------------
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_vec      <= 5'd0;
            r_hold     <= 4'd0;
            r_stim     <= 5'd0;
            r_err_cnt  <= '0;
            r_fail_vld <= 1'b0;
            r_fail_vec <= 5'd0;
            r_pass     <= 1'b0;
        end else if (w_start_take) begin
            r_vec      <= 5'd0;
            r_hold     <= 4'd0;
            r_stim     <= 5'd0;
            r_err_cnt  <= '0;
            r_fail_vld <= 1'b0;
            r_fail_vec <= 5'd0;
            r_pass     <= 1'b0;
        end else if (r_state == ST_RUN) begin
            if (w_last_hold) begin
                if (w_mismatch) begin
                    if (r_err_cnt != LP_ERR_MAX) begin
                        r_err_cnt <= r_err_cnt + 1'b1;
                    end
                    // Only the first mismatch of a run records its vector.
                    if (!r_fail_vld) begin
                        r_fail_vld <= 1'b1;
                        r_fail_vec <= r_vec;
                    end
                end
                r_hold <= 4'd0;
                if (w_last_vec) begin
                    // The final compare result is folded in here. The
                    // registered counters only see it one edge later.
                    r_pass <= (r_err_cnt == '0) && !r_fail_vld && !w_mismatch;
                    r_vec  <= 5'd0;
                    r_stim <= 5'd0;
                end else begin
                    r_vec  <= r_vec + 5'd1;
                    r_stim <= r_vec + 5'd1;
                end
            end else begin
                r_hold <= r_hold + 4'd1;
            end
        end
    end

`ifdef AOI221_BIST_FAILMAP_EN
    logic [31:0] r_fail_map;

    // The bitmap ignores counter saturation: every failing vector is marked.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_fail_map <= 32'd0;
        end else if (w_start_take) begin
            r_fail_map <= 32'd0;
        end else if (w_last_hold && w_mismatch) begin
            r_fail_map[r_vec] <= 1'b1;
        end
    end

    assign FAIL_MAP = r_fail_map;
`endif

    assign {A, B1, B2, C1, C2} = r_stim;
    assign BUSY      = w_busy;
    assign DONE      = w_done;
    assign PASS      = r_pass;
    assign ERR_CNT   = r_err_cnt;
    assign FAIL_VLD  = r_fail_vld;
    assign FAIL_VEC  = r_fail_vec;
    assign DBG_STATE = r_state;

endmodule

// File: doc/aoi221_bist_ctrl.md
Name: aoi221_bist_ctrl

Overview:
- Self-test controller placed around a single AOI221 cell instance.
- Upstream: drives the cell's five inputs A, B1, B2, C1, C2 through all 32 input patterns.
- Downstream: samples the cell's ZN output and compares it against the golden function ZN = ~(A | (B1&B2) | (C1&C2)).
- Used for gate-level and post-layout functional characterization of the cell. Reports pass/fail, mismatch count and the first failing vector.

Parameters:
- SETTLE_CYCLES, 2: extra hold cycles per vector before ZN is sampled. Range 0..15.
- ERR_CNT_W, 6: width of the mismatch counter. Minimum 1.

Ports:
- CK  input  1  clock, rising-edge.
- RN  input  1  asynchronous active-low reset.
- START  input  1  begin a 32-vector run. Honoured only in IDLE or DONE.
- ZN_IN  input  1  ZN from the cell under test.
- A  output  1  stimulus to the cell, equal to VEC[4].
- B1  output  1  stimulus to the cell, equal to VEC[3].
- B2  output  1  stimulus to the cell, equal to VEC[2].
- C1  output  1  stimulus to the cell, equal to VEC[1].
- C2  output  1  stimulus to the cell, equal to VEC[0].
- BUSY  output  1  high while vectors are being applied.
- DONE  output  1  one-cycle pulse when a run completes.
- PASS  output  1  high when the last completed run had zero mismatches. Held until the next START.
- ERR_CNT  output  ERR_CNT_W  mismatches in the current or last run. Saturating.
- FAIL_VLD  output  1  at least one mismatch seen in the current or last run.
- FAIL_VEC  output  5  index of the first mismatching vector. Valid when FAIL_VLD=1.

Behaviour:
- Reset (RN=0, asynchronous):
  - State = IDLE, VEC=0, hold counter=0.
  - All outputs 0: A, B1, B2, C1, C2, BUSY, DONE, PASS, ERR_CNT, FAIL_VLD, FAIL_VEC.
  - Reset mid-run aborts the run immediately. No DONE pulse. Results cleared.
- States: IDLE, RUN, FIN.
  - IDLE / FIN with START=1: go to RUN on the next edge. VEC=0, hold counter=0, ERR_CNT=0, FAIL_VLD=0, FAIL_VEC=0, PASS=0.
  - RUN: vector VEC is driven for SETTLE_CYCLES+1 cycles. On the edge ending the last hold cycle, ZN_IN is compared with the golden value of VEC.
  - RUN after the compare: if VEC==31, go to FIN; otherwise VEC increments and the hold counter resets.
  - FIN: DONE=1 for exactly the first FIN cycle. PASS=(ERR_CNT==0 and FAIL_VLD==0). Stimulus returns to 0.
- Outputs by state:
  - BUSY=1 exactly in RUN.
  - Stimulus outputs are 0 in IDLE and FIN.
  - Stimulus outputs are registered: no combinational path from START to A..C2.
- Timing: with START sampled at edge t0, vector 0 is driven during cycle 1 and vector k occupies cycles k*(SETTLE_CYCLES+1)+1 .. (k+1)*(SETTLE_CYCLES+1). DONE is high in cycle 32*(SETTLE_CYCLES+1)+1.
- Compare rule: 4-state. X or Z on ZN_IN counts as a mismatch.
- ERR_CNT saturates at 2^ERR_CNT_W-1. FAIL_VLD stays set even when saturated.
- FAIL_VEC captures VEC on the first mismatch of a run only. Later mismatches do not overwrite it.
- START while in RUN is ignored.
- START held high through FIN restarts a run on the next edge, after the DONE cycle.
- SETTLE_CYCLES=0: one cycle per vector, compare every cycle.

Optional Feature:
- Macro: AOI221_BIST_FAILMAP_EN.
- Defined: an extra output FAIL_MAP (32 bits, reset 0, cleared on START). Bit k is set when vector k mismatches. Unaffected by ERR_CNT saturation.
- Not defined: no FAIL_MAP port and no associated flops. All other behaviour is identical.

Test Plan:
- Good cell, SETTLE_CYCLES=2, START pulse at t0:
  - BUSY high in cycles 1..96, DONE in cycle 97.
  - PASS=1, ERR_CNT=0, FAIL_VLD=0.
  - A..C2 walk 00000..11111, each vector held 3 cycles.
- ZN_IN stuck at 0 → ERR_CNT=9, FAIL_VLD=1, FAIL_VEC=0, PASS=0.
  - With FAILMAP: FAIL_MAP=0x00000777.
- ZN_IN stuck at 1 with ERR_CNT_W=4 → ERR_CNT saturates at 15 (true count 23), FAIL_VEC=3, PASS=0.
- RN low for one cycle at cycle 40 of a run → all outputs 0 immediately, no DONE pulse. A new START gives a clean full run with a correct result.
- START re-pulsed in cycle 10 of a run → ignored; DONE still in cycle 97. Then START held high through FIN → DONE pulses once, BUSY rises the following cycle.
- SETTLE_CYCLES=0, good cell → DONE in cycle 33, PASS=1. ZN_IN driven X at vector 5 only → ERR_CNT=1, FAIL_VEC=5.
